axi_slave_ram_responder: RTL

AXI_SLAVE_RAM_RESPONDER -- requirements
Module: axi_slave_ram_responder

---
 rtl/axi_slave_ram_responder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_ram_responder.sv
// AXI-style slave RAM with independent write and read burst FSMs.
// Optional byte-strobe writes are enabled by defining SLAVE_RAM_STRB_EN.
module axi_slave_ram_responder #(
  parameter int unsigned ADDR_WIDTH_WORDS = 8,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [1:0]  WR_ADDR_ID,
  input  logic [31:0] WR_ADDR,
  input  logic [7:0]  WR_ADDR_LEN,
  input  logic [1:0]  WR_ADDR_BURST,
  input  logic        WR_ADDR_VALID,
  output logic        WR_ADDR_READY,
  input  logic [31:0] WR_DATA,
  input  logic [3:0]  WR_STRB,
  input  logic        WR_DATA_LAST,
  input  logic        WR_DATA_VALID,
  output logic        WR_DATA_READY,
  output logic [1:0]  WR_BACK_ID,
  output logic [1:0]  WR_BACK_RESP,
  output logic        WR_BACK_VALID,
  input  logic        WR_BACK_READY,
  input  logic [1:0]  RD_ADDR_ID,
  input  logic [31:0] RD_ADDR,
  input  logic [7:0]  RD_ADDR_LEN,
  input  logic [1:0]  RD_ADDR_BURST,
  input  logic        RD_ADDR_VALID,
  output logic        RD_ADDR_READY,
  output logic [1:0]  RD_BACK_ID,
  output logic [31:0] RD_DATA,
  output logic [1:0]  RD_DATA_RESP,
  output logic        RD_DATA_LAST,
  output logic        RD_DATA_VALID,
  input  logic        RD_DATA_READY
);

  localparam int unsigned Words       = 1 << ADDR_WIDTH_WORDS;
  localparam logic [32:0] WindowBytes = 33'd4 << ADDR_WIDTH_WORDS;
  localparam logic [1:0]  RespOkay    = 2'b00;
  localparam logic [1:0]  RespSlvErr  = 2'b10;
  localparam logic [1:0]  RespDecErr  = 2'b11;
  localparam logic [1:0]  BurstFixed  = 2'b00;
  localparam logic [1:0]  BurstIncr   = 2'b01;

  typedef logic [ADDR_WIDTH_WORDS-1:0] idx_t;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [31:0] mem_q [Words];

  function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic [1:0] burst);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if ({1'b0, off} >= WindowBytes) return RespDecErr;
    if (burst != BurstFixed && burst != BurstIncr) return RespSlvErr;
    return RespOkay;
  endfunction

  function automatic idx_t word_idx(input logic [31:0] addr);
    return idx_t'((addr - BASE_ADDR) >> 2);
  endfunction

  // Write channel state
  w_state_e    w_state_q, w_state_d;
  logic [1:0]  w_id_q, w_id_d, w_resp_q, w_resp_d;
  idx_t        w_idx_q, w_idx_d;
  logic        w_incr_q, w_incr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [8:0]  w_cnt_q, w_cnt_d;
  logic        mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_incr_d  = w_incr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_resp_d  = w_resp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: if (WR_ADDR_VALID) begin
        w_id_d    = WR_ADDR_ID;
        w_idx_d   = word_idx(WR_ADDR);
        w_incr_d  = (WR_ADDR_BURST == BurstIncr);
        w_len_d   = WR_ADDR_LEN;
        w_cnt_d   = '0;
        w_resp_d  = decode_resp(WR_ADDR, WR_ADDR_BURST);
        w_state_d = WData;
      end
      WData: if (WR_DATA_VALID) begin
        // Error bursts are dropped; a length mismatch is only known at LAST.
        mem_we = (w_resp_q == RespOkay);
        if (w_incr_q) w_idx_d = w_idx_q + idx_t'(1);
        if (w_cnt_q != '1) w_cnt_d = w_cnt_q + 9'd1;
        if (WR_DATA_LAST) begin
          if (w_cnt_q != {1'b0, w_len_q} && w_resp_q == RespOkay) w_resp_d = RespSlvErr;
          w_state_d = WResp;
        end
      end
      WResp: if (WR_BACK_READY) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_incr_q  <= 1'b0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_incr_q  <= w_incr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
`ifdef SLAVE_RAM_STRB_EN
      for (int b = 0; b < 4; b++) begin
        if (WR_STRB[b]) mem_q[w_idx_q][8*b +: 8] <= WR_DATA[8*b +: 8];
      end
`else
      mem_q[w_idx_q] <= WR_DATA;
`endif
    end
  end

`ifndef SLAVE_RAM_STRB_EN
  logic unused_strb;
  assign unused_strb = ^WR_STRB;
`endif

  // Read channel state; beat data is fetched at the preceding handshake so it
  // stays stable under stalls and reflects pre-write contents.
  r_state_e    r_state_q, r_state_d;
  logic [1:0]  r_id_q, r_id_d, r_resp_q, r_resp_d;
  idx_t        r_idx_q, r_idx_d, r_idx_nxt;
  logic        r_incr_q, r_incr_d;
  logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [31:0] r_data_q, r_data_d;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_incr_d  = r_incr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    r_idx_nxt = r_incr_q ? r_idx_q + idx_t'(1) : r_idx_q;
    unique case (r_state_q)
      RIdle: if (RD_ADDR_VALID) begin
        r_id_d    = RD_ADDR_ID;
        r_idx_d   = word_idx(RD_ADDR);
        r_incr_d  = (RD_ADDR_BURST == BurstIncr);
        r_len_d   = RD_ADDR_LEN;
        r_cnt_d   = '0;
        r_resp_d  = decode_resp(RD_ADDR, RD_ADDR_BURST);
        r_data_d  = (r_resp_d == RespOkay) ? mem_q[r_idx_d] : '0;
        r_state_d = RData;
      end
      RData: if (RD_DATA_READY) begin
        if (r_cnt_q == r_len_q) begin
          r_state_d = RIdle;
        end else begin
          r_cnt_d  = r_cnt_q + 8'd1;
          r_idx_d  = r_idx_nxt;
          r_data_d = (r_resp_q == RespOkay) ? mem_q[r_idx_nxt] : '0;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_incr_q  <= 1'b0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_incr_q  <= r_incr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

  assign WR_ADDR_READY = RSTN && (w_state_q == WIdle);
  assign WR_DATA_READY = (w_state_q == WData);
  assign WR_BACK_VALID = (w_state_q == WResp);
  assign WR_BACK_ID    = WR_BACK_VALID ? w_id_q : '0;
  assign WR_BACK_RESP  = WR_BACK_VALID ? w_resp_q : '0;

  assign RD_ADDR_READY = RSTN && (r_state_q == RIdle);
  assign RD_DATA_VALID = (r_state_q == RData);
  assign RD_BACK_ID    = RD_DATA_VALID ? r_id_q : '0;
  assign RD_DATA       = RD_DATA_VALID ? r_data_q : '0;
  assign RD_DATA_RESP  = RD_DATA_VALID ? r_resp_q : '0;
  assign RD_DATA_LAST  = RD_DATA_VALID && (r_cnt_q == r_len_q);

endmodule
